// File: rtl/seg_pkg.sv
// Shared constants for the four-digit seven-segment scanner: active-low
// segment patterns in {g,f,e,d,c,b,a} order, the blank pattern and the digit count.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    typedef enum logic {
        FLASH_OFF = 1'b0,
        FLASH_ON  = 1'b1
    } flash_phase_t;

endpackage

// File: rtl/seg_display_scan_if.sv
// Signal bundle between a digit source and the display scanner; the scanner
// also reports its current slot index for observation.
interface seg_display_scan_if;

    logic [3:0] val1;
    logic [3:0] val2;
    logic [3:0] val3;
    logic [3:0] val4;
    logic       flash_en;
    logic [3:0] an;
    logic [6:0] led_seg;
    logic       frame_tick;
    logic [1:0] slot;

    modport master (
        output val1, val2, val3, val4, flash_en,
        input  an, led_seg, frame_tick, slot
    );

    modport slave (
        input  val1, val2, val3, val4, flash_en,
        output an, led_seg, frame_tick, slot
    );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show blank.
import seg_pkg::*;

module bcd_to_seg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-aligned digit capture
// and optional flashing. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
import seg_pkg::*;

module seg_display_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst,
    seg_display_scan_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int FL_W  = $clog2(FLASH_FRAMES + 1);

    logic [CNT_W-1:0]                cnt;
    logic [1:0]                      slot;
    logic                            started;
    logic [NUM_DIGITS-1:0][3:0]      shadow;
    logic [FL_W-1:0]                 fcnt;
    flash_phase_t                    phase;
    logic [3:0]                      an_q;
    logic [6:0]                      seg_q;
    logic                            tick_q;

    logic                            tc;
    logic                            wrap;
    logic                            phase_on;
    logic [3:0]                      digit;
    logic [6:0]                      seg_raw;
    logic [6:0]                      seg_next;

    assign tc       = (cnt == CNT_W'(REFRESH_DIV - 1));
    // The first cycle out of reset behaves like a frame wrap so digits are captured before slot 0.
    assign wrap     = !started || (tc && (slot == 2'd3));
    assign phase_on = !bus.flash_en || (phase == FLASH_ON);
    assign digit    = shadow[slot];

    bcd_to_seg u_dec (
        .digit (digit),
        .seg   (seg_raw)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;
    assign lz[3] = (shadow[3] == 4'd0);
    assign lz[2] = lz[3] && (shadow[2] == 4'd0);
    assign lz[1] = lz[2] && (shadow[1] == 4'd0);
    assign lz[0] = 1'b0;
    assign seg_next = lz[slot] ? SEG_BLANK : seg_raw;
`else
    assign seg_next = seg_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            slot    <= 2'd0;
            started <= 1'b0;
            shadow  <= '0;
            tick_q  <= 1'b0;
        end else begin
            started <= 1'b1;
            tick_q  <= wrap;
            cnt     <= (!started || tc) ? '0 : cnt + 1'b1;
            if (started && tc)
                slot <= slot + 2'd1;
            if (wrap)
                shadow <= {bus.val4, bus.val3, bus.val2, bus.val1};
        end
    end

    // Phase toggles on the first frame wrap of each FLASH_FRAMES group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt  <= '0;
            phase <= FLASH_ON;
        end else if (!bus.flash_en) begin
            fcnt  <= '0;
            phase <= FLASH_ON;
        end else if (wrap) begin
            if (fcnt == '0)
                phase <= (phase == FLASH_ON) ? FLASH_OFF : FLASH_ON;
            fcnt <= (fcnt == FL_W'(FLASH_FRAMES - 1)) ? '0 : fcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= (started && phase_on) ? ~(4'b0001 << slot) : AN_OFF;
            seg_q <= started ? seg_next : SEG_BLANK;
        end
    end

    assign bus.an         = an_q;
    assign bus.led_seg    = seg_q;
    assign bus.frame_tick = tick_q;
    assign bus.slot       = slot;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with REFRESH_DIV = 4, FLASH_FRAMES = 2.
// Frame f drives slot 0 from negedge 16f+2; its frame_tick is seen at negedge 16f+1.
module tb_seg_display_scan;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   n           = 0;
    logic [3:0] exp_q[$];
    logic [3:0] pat;
    logic [6:0] lz_exp;

    seg_display_scan_if bus ();

    seg_display_scan #(
        .REFRESH_DIV  (4),
        .FLASH_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (negedge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic step_to(input int t);
        while (n < t) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic set_vals(input logic [3:0] v4, input logic [3:0] v3,
                            input logic [3:0] v2, input logic [3:0] v1);
        bus.val4 = v4;
        bus.val3 = v3;
        bus.val2 = v2;
        bus.val1 = v1;
    endtask

    initial begin
        rst = 1'b1;
        bus.flash_en = 1'b0;
        set_vals(4'd0, 4'd0, 4'd0, 4'd0);
        repeat (3) @(negedge clk);
        check("rst_an", bus.an, 4'b1111);
        check("rst_seg", bus.led_seg, 7'h7F);
        check("rst_tick", bus.frame_tick, 1'b0);
        check("rst_slot", bus.slot, 2'd0);

        // Scan order and decode with val4..val1 = 1,2,3,4
        set_vals(4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        step_to(1);
        check("first_tick", bus.frame_tick, 1'b1);
        check("first_an_off", bus.an, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            pat = 4'b0001 << k;
            for (int r = 0; r < 4; r++) exp_q.push_back(~pat);
        end
        for (int i = 2; i <= 17; i++) begin
            step_to(i);
            check("scan_an", bus.an, exp_q.pop_front());
            if (i == 2) begin
                check("tick_low", bus.frame_tick, 1'b0);
                check("slot0_seg4", bus.led_seg, 7'b0011001);
            end
            if (i == 14) check("slot3_seg1", bus.led_seg, 7'b1111001);
            if (i == 17) check("second_tick", bus.frame_tick, 1'b1);
        end

        // Mid-frame change during slot 2 of frame 1
        step_to(26);
        set_vals(4'd7, 4'd2, 4'd3, 4'd0);
        step_to(30);
        check("mid_slot3_old", bus.led_seg, 7'b1111001);
        step_to(33);
        check("mid_tick", bus.frame_tick, 1'b1);
        step_to(34);
        check("mid_slot0_new", bus.led_seg, 7'b1000000);
        step_to(46);
        check("mid_slot3_new", bus.led_seg, 7'b1111000);

        // Leading zeros: val4..val1 = 0,0,4,0
`ifdef LEADING_ZERO_BLANK_EN
        lz_exp = 7'h7F;
`else
        lz_exp = 7'b1000000;
`endif
        step_to(47);
        set_vals(4'd0, 4'd0, 4'd4, 4'd0);
        step_to(50);
        check("lz_slot0", bus.led_seg, 7'b1000000);
        step_to(54);
        check("lz_slot1", bus.led_seg, 7'b0011001);
        step_to(58);
        check("lz_slot2", bus.led_seg, lz_exp);
        step_to(62);
        check("lz_slot3", bus.led_seg, lz_exp);

        // Non-BCD codes blank: val4..val1 = 9,15,8,10
        step_to(63);
        set_vals(4'd9, 4'd15, 4'd8, 4'd10);
        step_to(66);
        check("code10_blank", bus.led_seg, 7'h7F);
        step_to(70);
        check("code8", bus.led_seg, 7'b0000000);
        step_to(74);
        check("code15_blank", bus.led_seg, 7'h7F);
        step_to(78);
        check("code9", bus.led_seg, 7'b0010000);

        // Flash: enabled mid-frame 5, off for frames 6-7, on for 8-9, off from 10
        step_to(83);
        bus.flash_en = 1'b1;
        step_to(97);
        check("flash_pre_an", bus.an, 4'b0111);
        check("flash_tick", bus.frame_tick, 1'b1);
        step_to(98);
        check("flash_off_a", bus.an, 4'b1111);
        step_to(106);
        check("flash_off_b", bus.an, 4'b1111);
        step_to(114);
        check("flash_off_c", bus.an, 4'b1111);
        step_to(125);
        check("flash_off_d", bus.an, 4'b1111);
        step_to(130);
        check("flash_on_a", bus.an, 4'b1110);
        step_to(134);
        check("flash_on_b", bus.an, 4'b1101);
        step_to(146);
        check("flash_on_c", bus.an, 4'b1110);
        step_to(162);
        check("flash_off_e", bus.an, 4'b1111);
        step_to(163);
        check("flash_off_f", bus.an, 4'b1111);
        bus.flash_en = 1'b0;
        step_to(164);
        check("flash_drop", bus.an, 4'b1110);

        // Asynchronous reset between edges during slot 2 of frame 11
        step_to(187);
        check("pre_rst_an", bus.an, 4'b1011);
        #1;
        rst = 1'b1;
        #1;
        check("async_an", bus.an, 4'b1111);
        check("async_seg", bus.led_seg, 7'h7F);
        check("async_slot", bus.slot, 2'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        step_to(1);
        check("rerun_tick", bus.frame_tick, 1'b1);
        check("rerun_an_off", bus.an, 4'b1111);
        step_to(2);
        check("rerun_slot0_an", bus.an, 4'b1110);
        check("rerun_slot0_seg", bus.led_seg, 7'h7F);
        step_to(6);
        check("rerun_slot1_an", bus.an, 4'b1101);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_display_scan.md
SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit is driven per scan slot (minimum 2).
REQ-002 Parameter FLASH_FRAMES, default 64, full scan frames per flash half-period (minimum 1).
REQ-003 clk  input  1  system clock; all state is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 val1  input  4  BCD ones digit; val2, val3, val4 are likewise 4-bit inputs, with val4 the most significant digit.
REQ-006 flash_en  input  1  level; high requests a blinking display.
REQ-007 an  output  4  anode enables, active-low; an[0] drives val1 and an[3] drives val4.
REQ-008 led_seg  output  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.
REQ-009 frame_tick  output  1  one-cycle pulse at the start of each scan frame.

Function
REQ-010 A refresh counter shall count 0..REFRESH_DIV-1 and wrap; on its terminal count the 2-bit slot index shall advance 0->1->2->3->0.
REQ-011 an and led_seg shall be registered and change exactly one clk after the refresh terminal count.
REQ-012 On the slot index wrap 3->0, val1..val4 shall be captured into a shadow register; input changes mid-frame shall not be visible until the next frame.
REQ-013 frame_tick shall pulse high for exactly one clk in the same cycle the shadow register updates.
REQ-014 Slot k shall drive an = ~(1<<k) with led_seg = the decoded shadow digit k+1.
REQ-015 Decode: BCD 0-9 use standard segments, e.g. 0 = 7'b1000000 and 4 = 7'b0011001; codes 10-15 shall show blank (7'h7F).
REQ-016 A flash counter shall count frames; the flash phase shall toggle every FLASH_FRAMES frames while flash_en is high.
REQ-017 During the off flash phase, an shall be 4'b1111; the scan and the shadow captures shall continue.
REQ-018 When flash_en goes low, the flash counter shall clear and the phase shall force to on within one clk.
REQ-019 A flash toggle coinciding with a digit capture shall take both effects in the same cycle.

Reset
REQ-020 While rst is high: an = 4'b1111, led_seg = 7'h7F, frame_tick = 0, counters and slot index = 0, shadow digits = 0, flash phase = on.
REQ-021 After rst releases, the first frame shall start with a capture and a frame_tick, and slot 0 shall be driven one clk later.
REQ-022 rst asserted mid-frame shall take effect immediately, without waiting for a clk edge.

Configuration
REQ-023 With LEADING_ZERO_BLANK_EN defined, a zero digit shall show 7'h7F if it and every more-significant digit are zero; val1 shall never be blanked.
REQ-024 Without LEADING_ZERO_BLANK_EN, all four digits shall always be decoded.

Structure
REQ-025 Shared package seg_pkg shall hold the segment encoding constants, the blank pattern, and NUM_DIGITS = 4.
REQ-026 Sub-module bcd_to_seg shall be a purely combinational 4-bit-to-7-segment decoder, instantiated once on the muxed shadow digit.

Verification (REFRESH_DIV = 4, FLASH_FRAMES = 2)
REQ-027 Reset: hold rst high -> an = 1111, led_seg = 7F, frame_tick = 0; release -> frame_tick pulses, then an cycles 1110, 1101, 1011, 0111 with 4 clk each.
REQ-028 Decode: val4..val1 = 1,2,3,4 -> slot 0 shows led_seg = 0011001; slot 3 shows the decode of 1 (1111001).
REQ-029 Mid-frame change: set val1 from 4 to 0 during slot 2 -> slot 0 keeps 0011001 until the next frame_tick, then shows 1000000.
REQ-030 Blanking (macro on): val4..val1 = 0,0,4,0 -> slots 3 and 2 show 7F, slot 1 shows 0011001, slot 0 shows 1000000; with the macro off, slots 3 and 2 show 1000000.
REQ-031 Flash: flash_en = 1 -> an = 1111 for 2 frames, then normal for 2 frames, repeating; dropping flash_en -> normal scan on the next clk.
REQ-032 Async reset: assert rst between clk edges in slot 2 -> an = 1111 immediately; after release, the scan restarts at slot 0.
